// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO; latency 34 edges start->done (fast MUL 2 with MULDIV_FAST_MUL_EN).
// Stalls pipeline via busy (state != IDLE); start/hi_we/lo_we ignored while busy; flush aborts to IDLE.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic        sign_a, sign_b;
    logic [31:0] mag_a, mag_b;
    logic [4:0]  cnt;
    logic [63:0] acc;

    logic        a_neg_in, b_neg_in, fast_mul_go;
    logic [31:0] mag_a_in, mag_b_in;
    logic [32:0] mul_sum;
    logic [63:0] mul_step, div_step, prod;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem, quo, rem, res_hi, res_lo;

    assign busy = (state != IDLE);

    // op[0]==0 selects the signed variants
    assign a_neg_in = ~op[0] & a[31];
    assign b_neg_in = ~op[0] & b[31];
    assign mag_a_in = a_neg_in ? -a : a;
    assign mag_b_in = b_neg_in ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul_go = ~op[1];
`else
    assign fast_mul_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast_mul_go ? FIN : CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Multiply: acc = {partial product, remaining multiplier bits}
    // Divide:   acc = {partial remainder, remaining dividend bits / quotient bits}
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
        mul_step  = {mul_sum, acc[31:1]};
        div_shift = {acc[63:32], acc[31]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_rem   = div_ge ? (div_shift[31:0] - mag_b) : div_shift[31:0];
        div_step  = {div_rem, acc[30:0], div_ge};
    end

    always_comb begin
        prod = ((op_q == 2'b00) && (sign_a ^ sign_b)) ? -acc : acc;
        quo  = acc[31:0];
        rem  = acc[63:32];
        if (op_q == 2'b10) begin
            if (sign_a ^ sign_b) quo = -quo;
            if (sign_a)          rem = -rem;
        end
        if (!op_q[1]) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (mag_b == 32'd0) begin
            // Divide by zero returns the original dividend in HI
            res_hi = sign_a ? -mag_a : mag_a;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 2'b00;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= 32'd0;
            mag_b  <= 32'd0;
            cnt    <= 5'd0;
            acc    <= 64'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            done   <= 1'b0;
        end else begin
            done <= (state == FIN) && !flush;
            case (state)
                IDLE: if (!flush) begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        op_q   <= op;
                        sign_a <= a_neg_in;
                        sign_b <= b_neg_in;
                        mag_a  <= mag_a_in;
                        mag_b  <= mag_b_in;
                        cnt    <= 5'd0;
                        if (fast_mul_go)
                            acc <= {32'd0, mag_a_in} * {32'd0, mag_b_in};
                        else
                            acc <= op[1] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
                    end
                end
                CALC: if (!flush) begin
                    acc <= op_q[1] ? div_step : mul_step;
                    cnt <= cnt + 5'd1;
                end
                FIN: if (!flush) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result table plus hand sequences for
// MTHI/MTLO, ignored inputs while busy, flush, back-to-back issue and async reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2, MUL_BUSY = 1;
`else
    localparam int MUL_LAT = 34, MUL_BUSY = 33;
`endif
    localparam int DIV_LAT = 34, DIV_BUSY = 33;

    muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    int busy_cnt, done_cnt, done_at;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op; optionally pulse hi_we/lo_we/start (inj_k) or flush (flush_k) at sample k.
    task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input int inj_k, input int flush_k);
        op = o; a = va; b = vb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= 45; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            hi_we = (k == inj_k);
            lo_we = (k == inj_k);
            start = (k == inj_k);
            if (k == inj_k) begin
                wdata = 32'hDEAD_BEEF;
                op = MULTU;
                a = 32'd3;
                b = 32'd3;
            end
            flush = (k == flush_k);
            @(negedge clk);
        end
        hi_we = 1'b0; lo_we = 1'b0; start = 1'b0; flush = 1'b0;
    endtask

    initial begin
        vecs[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[2] = '{MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[5] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[6] = '{DIVU,  32'd5,         32'd0,         32'h0000_0005, 32'hFFFF_FFFF};
        vecs[7] = '{DIV,   32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFF8, 32'hFFFF_FFFF};
        vecs[8] = '{DIVU,  32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF};

        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 0);
            check($sformatf("v%0d hi", i), hi, vecs[i].exp_hi);
            check($sformatf("v%0d lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d done count", i), done_cnt, 32'd1);
            check($sformatf("v%0d done latency", i), done_at, vecs[i].op[1] ? DIV_LAT : MUL_LAT);
            check($sformatf("v%0d busy cycles", i), busy_cnt, vecs[i].op[1] ? DIV_BUSY : MUL_BUSY);
        end

        // MTHI / MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
        @(negedge clk);
        lo_we = 1'b0;
        check("mthi", hi, 32'h1234_5678);
        check("mtlo", lo, 32'h0BAD_F00D);

        // hi_we/lo_we/start mid-CALC are ignored
        run_op(DIVU, 32'd100, 32'd7, 10, 0);
        check("inject hi", hi, 32'd2);
        check("inject lo", lo, 32'd14);
        check("inject done count", done_cnt, 32'd1);
        check("inject busy cycles", busy_cnt, 32'd33);

        // flush at CALC step 10
        run_op(DIVU, 32'd50, 32'd3, 0, 11);
        check("flush done count", done_cnt, 32'd0);
        check("flush busy cycles", busy_cnt, 32'd11);
        check("flush hi", hi, 32'd2);
        check("flush lo", lo, 32'd14);

        // flush together with start in IDLE
        op = DIVU; a = 32'd9; b = 32'd2; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush+start busy", {31'd0, busy}, 32'd0);

        // back-to-back issue in the done cycle
        op = DIVU; a = 32'd9; b = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_at = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done) begin done_at = k; break; end
            @(negedge clk);
        end
        check("b2b first done", done_at, 32'd34);
        check("b2b first lo", lo, 32'd4);
        op = DIVU; a = 32'd20; b = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b accepted busy", {31'd0, busy}, 32'd1);
        done_at = -1;
        for (int k = 1; k <= 60; k++) begin
            if (done) begin done_at = k; break; end
            @(negedge clk);
        end
        check("b2b second done", done_at, 32'd34);
        check("b2b second hi", hi, 32'd2);
        check("b2b second lo", lo, 32'd3);

        // asynchronous reset mid-CALC
        op = DIVU; a = 32'd77; b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst done", {31'd0, done}, 32'd0);
        check("arst hi", hi, 32'd0);
        check("arst lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post-arst done", {31'd0, done}, 32'd0);
        check("post-arst busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with its own HI/LO register pair, sitting directly downstream of the general-purpose register file in the execute stage. It consumes the two register-file read operands (rs on `a`, rt on `b`) and runs MULT/MULTU/DIV/DIVU over multiple cycles, raising `busy` so the pipeline stalls. It also supports direct HI/LO writes for MTHI/MTLO. Results are read back on `hi`/`lo` for MFHI/MFLO.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: launch operation `op`; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` input 32: operand rs (multiplicand / dividend).
- `b` input 32: operand rt (multiplier / divisor).
- `flush` input 1: abort any in-flight operation.
- `hi_we` input 1: write `wdata` to HI (MTHI).
- `lo_we` input 1: write `wdata` to LO (MTLO).
- `wdata` input 32: MTHI/MTLO data.
- `busy` output 1: operation in flight (state != IDLE).
- `done` output 1: one-cycle pulse; HI/LO hold the new result.
- `hi` output 32: HI register.
- `lo` output 32: LO register.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: on `start` (and no `flush`), latch `op`, record operand signs, latch magnitudes (two's-complement absolute value for MULT/DIV, raw for MULTU/DIVU), clear the 5-bit counter, go to CALC.
- CALC: one radix-2 step per cycle, 32 steps (counter 0..31). Multiply: shift-add into a 64-bit accumulator. Divide: restoring, 1 quotient bit per step. At counter 31, go to FIN.
- FIN: apply sign fix, write HI/LO, pulse `done`, go to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]. For MULT, the product is negated when the operand signs differ.
- Divide result: LO = quotient, HI = remainder. For DIV, the quotient is negated when the signs differ, and the remainder takes the dividend's sign.
- Divide by zero (`b` == 0, either divide op): normal latency; HI = original `a`, LO = 32'hFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `start` while busy: ignored.
- `hi_we`/`lo_we`:
  - Honoured only in IDLE; ignored while busy.
  - If asserted with `start` in IDLE, the write lands now and the later result overwrites it.
- `flush`: in any state, the next edge returns to IDLE. No `done`; HI/LO unchanged. `flush` with `start` in IDLE: start is ignored.

## Timing
- Reset (async assert, sync-safe release): state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `start` accepted at edge N:
  - `busy` is high from N through N+33.
  - CALC steps occur at edges N+1..N+32.
  - FIN occurs at edge N+33: HI/LO are updated and `done`=1 for exactly one cycle (N+33 to N+34), with `busy` already 0.
- A new `start` may be accepted in the same cycle `done` is high (back-to-back issue, 34-cycle throughput).
- `busy` is decoded from the state register (no combinational path from inputs). `hi`/`lo`/`done` are registered.
- HI/LO direct writes take effect at the next edge.
- `rst_n` asserted mid-operation: immediate return to the reset values.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MULT/MULTU compute a single-cycle 64-bit product in IDLE and go straight to FIN. `start` at edge N gives `done` during N+1 to N+2, with `busy` high only from N to N+1. Divides are unchanged.
- Undefined: all ops use the 32-step iterative path described above.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 edges, `done` pulses once, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; `busy` high for exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. Then DIVU a=5, b=0 -> HI=5, LO=0xFFFFFFFF.
- MTHI wdata=0x12345678 in IDLE -> HI=0x12345678. Then DIVU 100/7 issued, with `hi_we`, `lo_we` and `start` pulsed mid-CALC -> all three ignored; final LO=14, HI=2; `done` exactly once.
- Start DIVU, assert `flush` at CALC step 10 -> IDLE next edge, no `done`, HI/LO keep prior values. Separately, `rst_n` low mid-CALC -> `busy`/`done`/`hi`/`lo` all 0 immediately.
